// File: rtl/scfifo_normal_stream_reader.sv
// Drains a normal-mode scfifo (rdreq/q, fixed read latency) into a valid/ready stream
// through a READ_LATENCY+1 entry skid buffer. Optional macro: SCFIFO_READER_BYPASS_EN.
module scfifo_normal_stream_reader #(
  parameter int WIDTH        = 20,
  parameter int READ_LATENCY = 2
) (
  input  logic             clock,
  input  logic             sclr_n,
  input  logic             fifo_empty,
  output logic             fifo_rdreq,
  input  logic [WIDTH-1:0] fifo_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       buf_level
);
  localparam int         BUF_DEPTH = READ_LATENCY + 1;
  localparam logic [1:0] PTR_LAST  = 2'(BUF_DEPTH - 1);
  localparam logic [1:0] LVL_FULL  = 2'(BUF_DEPTH);
  localparam logic [2:0] DEPTH3    = 3'(BUF_DEPTH);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  logic [READ_LATENCY-1:0] infl_q, infl_d;
  logic [WIDTH-1:0]        buf_q [BUF_DEPTH];
  logic [1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic                    arrive, pop, bypass, buf_wr, buf_rd;
  logic [2:0]              inflight_cnt, credit;

  assign arrive       = infl_q[READ_LATENCY-1];
  assign inflight_cnt = 3'($countones(infl_q));

`ifdef SCFIFO_READER_BYPASS_EN
  // An arriving word with an empty buffer is forwarded straight to the output.
  assign bypass    = arrive && (level_q == 2'd0);
  assign out_valid = (level_q != 2'd0) || bypass;
  assign out_data  = bypass ? fifo_q : buf_q[rd_ptr_q];
`else
  assign bypass    = 1'b0;
  assign out_valid = (level_q != 2'd0);
  assign out_data  = buf_q[rd_ptr_q];
`endif

  assign pop       = out_valid && out_ready;
  assign buf_wr    = arrive && !(bypass && out_ready);
  assign buf_rd    = pop && !bypass;
  assign buf_level = level_q;

  // Every in-flight read owns a buffer slot, so credit never exceeds the depth.
  assign credit     = {1'b0, level_q} + inflight_cnt - {2'b00, pop};
  assign fifo_rdreq = sclr_n && !fifo_empty && (credit < DEPTH3);

  always_comb begin
    infl_d    = '0;
    infl_d[0] = fifo_rdreq;
    for (int i = 1; i < READ_LATENCY; i++) infl_d[i] = infl_q[i-1];
    wr_ptr_d = wr_ptr_q;
    if (buf_wr) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? 2'd0 : wr_ptr_q + 2'd1;
    rd_ptr_d = rd_ptr_q;
    if (buf_rd) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? 2'd0 : rd_ptr_q + 2'd1;
    level_d = level_q + 2'(buf_wr) - 2'(buf_rd);
  end

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      infl_q   <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      level_q  <= 2'd0;
    end else begin
      infl_q   <= infl_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (buf_wr) buf_q[wr_ptr_q] <= fifo_q;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!sclr_n)
    !(buf_wr && !buf_rd && level_q == LVL_FULL));

endmodule

// File: tb/tb_scfifo_normal_stream_reader.sv
// Bench for scfifo_normal_stream_reader: two instances (READ_LATENCY 2 and 1) fed by FIFO models,
// a per-cycle stream/occupancy model, and directed literal checks.
module tb_scfifo_normal_stream_reader;
  localparam int W = 20;
`ifdef SCFIFO_READER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic sclr_n, out_ready, fifo_clr;
  logic [W-1:0] fmem [0:1023];
  int fwr = 0;
  int n_chk = 0;
  int n_fail = 0;

  int rq [2], fr [2], nv [2], fv [2], lv [2], l8 [2];
  logic [W-1:0] fd [2];
  int lat_exp [2];
  int dep [2];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int RL = (k == 0) ? 2 : 1;
    logic fifo_empty, fifo_rdreq, out_valid;
    logic [W-1:0] fifo_q, out_data, p1, p2;
    logic [1:0] buf_level;
    int frd = 0;

    // FIFO model: words fmem[frd..fwr-1], q arrives RL cycles after rdreq
    assign fifo_empty = (frd == fwr);
    assign fifo_q     = (RL == 2) ? p2 : p1;
    always @(posedge clock) begin
      if (fifo_clr) frd <= fwr;
      else if (fifo_rdreq) frd <= frd + 1;
      p1 <= fmem[frd];
      p2 <= p1;
    end

    scfifo_normal_stream_reader #(.WIDTH(W), .READ_LATENCY(RL)) dut (
      .clock(clock), .sclr_n(sclr_n), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
      .fifo_q(fifo_q), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .buf_level(buf_level));

    // Stream model: occupancy = words arrived - words taken; output is the next word in FIFO order.
    int lvl = 0;
    int exp_i = 0;
    bit h1 = 1'b0, h2 = 1'b0, prev_rst = 1'b0;
    always @(negedge clock) begin
      bit arrive, ev, ep, erq;
      int infl;
      arrive = (RL == 2) ? h2 : h1;
      infl   = (RL == 2) ? (int'(h1) + int'(h2)) : int'(h1);
      if (!sclr_n) begin
        chk($sformatf("rl%0d_rdreq_in_reset", RL), int'(fifo_rdreq), 0);
        if (prev_rst) begin
          chk($sformatf("rl%0d_valid_in_reset", RL), int'(out_valid), 0);
          chk($sformatf("rl%0d_level_in_reset", RL), int'(buf_level), 0);
        end
        lvl = 0; h1 = 1'b0; h2 = 1'b0;
        exp_i = fifo_clr ? fwr : frd;
        prev_rst = 1'b1;
      end else begin
        ev  = (lvl != 0) || (BYP && arrive);
        ep  = ev && out_ready;
        erq = !fifo_empty && (lvl + infl - int'(ep) < RL + 1);
        chk($sformatf("rl%0d_valid", RL), int'(out_valid), int'(ev));
        chk($sformatf("rl%0d_level", RL), int'(buf_level), lvl);
        chk($sformatf("rl%0d_rdreq", RL), int'(fifo_rdreq), int'(erq));
        chk($sformatf("rl%0d_rdreq_while_empty", RL), int'(fifo_rdreq && fifo_empty), 0);
        if (ev) chk($sformatf("rl%0d_data", RL), int'(out_data), int'(fmem[exp_i]));
        if (ep) exp_i++;
        lvl = lvl + int'(arrive) - int'(ep);
        h2 = h1;
        h1 = fifo_rdreq;
        prev_rst = 1'b0;
      end
    end
  end

  task automatic push(input logic [W-1:0] v);
    fmem[fwr] = v;
    fwr++;
  endtask

  function automatic void note(input int k, input int i, input logic r, input logic v,
                               input logic [W-1:0] d, input logic [1:0] l);
    if (r) begin rq[k]++; if (fr[k] < 0) fr[k] = i; end
    if (v) begin
      nv[k]++; lv[k] = i;
      if (fv[k] < 0) begin fv[k] = i; fd[k] = d; end
    end
    if (i == 8) l8[k] = int'(l);
  endfunction

  task automatic clr_stats();
    for (int k = 0; k < 2; k++) begin
      rq[k] = 0; fr[k] = -1; nv[k] = 0; fv[k] = -1; lv[k] = -1; l8[k] = -1; fd[k] = '0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      note(0, i, g[0].fifo_rdreq, g[0].out_valid, g[0].out_data, g[0].buf_level);
      note(1, i, g[1].fifo_rdreq, g[1].out_valid, g[1].out_data, g[1].buf_level);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    lat_exp[0] = BYP ? 2 : 3;
    lat_exp[1] = BYP ? 1 : 2;
    dep[0] = 3;
    dep[1] = 2;
    sclr_n = 1'b0; out_ready = 1'b1; fifo_clr = 1'b0;
    push(20'h000A5);
    clr_stats();

    // Reset held with a non-empty FIFO
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_rdreq_rl2", int'(g[0].fifo_rdreq), 0);
    chk("rst_rdreq_rl1", int'(g[1].fifo_rdreq), 0);
    chk("rst_valid_rl2", int'(g[0].out_valid), 0);
    chk("rst_valid_rl1", int'(g[1].out_valid), 0);
    chk("rst_level_rl2", int'(g[0].buf_level), 0);
    chk("rst_level_rl1", int'(g[1].buf_level), 0);
    @(posedge clock);
    #1;
    sclr_n = 1'b1;

    // Single word: exactly one read, issued in the first cycle after release
    clr_stats();
    run(8);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("one_word_rdreqs_%0d", k), rq[k], 1);
      chk($sformatf("one_word_first_rd_%0d", k), fr[k], 0);
      chk($sformatf("one_word_latency_%0d", k), fv[k] - fr[k], lat_exp[k]);
      chk($sformatf("one_word_data_%0d", k), int'(fd[k]), 'h0A5);
    end

    // Full-throughput streaming of 0..15
    for (int i = 0; i < 16; i++) push(W'(i));
    clr_stats();
    run(30);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stream_rdreqs_%0d", k), rq[k], 16);
      chk($sformatf("stream_words_%0d", k), nv[k], 16);
      chk($sformatf("stream_consecutive_%0d", k), lv[k] - fv[k], 15);
      chk($sformatf("stream_latency_%0d", k), fv[k] - fr[k], lat_exp[k]);
      chk($sformatf("stream_first_data_%0d", k), int'(fd[k]), 0);
      chk($sformatf("stream_steady_level_%0d", k), l8[k], BYP ? 0 : 1);
    end

    // Backpressure with 10 words queued
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(W'('h100 + i));
    clr_stats();
    run(12);
    for (int k = 0; k < 2; k++) chk($sformatf("bp_rdreqs_%0d", k), rq[k], dep[k]);
    chk("bp_level_rl2", int'(g[0].buf_level), 3);
    chk("bp_level_rl1", int'(g[1].buf_level), 2);
    chk("bp_data_rl2", int'(g[0].out_data), 'h100);
    chk("bp_data_rl1", int'(g[1].out_data), 'h100);
    out_ready = 1'b1;
    clr_stats();
    run(20);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("bp_release_rdreqs_%0d", k), rq[k], 10 - dep[k]);
      chk($sformatf("bp_release_words_%0d", k), nv[k], 10);
    end

    // Reset mid-stream with reads in flight; FIFO reset in the same cycle
    for (int i = 0; i < 10; i++) push(W'('h200 + i));
    run(3);
    sclr_n = 1'b0; fifo_clr = 1'b1;
    @(posedge clock);
    #1;
    sclr_n = 1'b1; fifo_clr = 1'b0;
    for (int i = 0; i < 4; i++) push(W'('h300 + i));
    clr_stats();
    run(12);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst_first_data_%0d", k), int'(fd[k]), 'h300);
      chk($sformatf("midrst_words_%0d", k), nv[k], 4);
    end

    // Randomized traffic, then drain
    for (int i = 0; i < 300; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) push(W'($urandom_range(0, 20'hFFFFF)));
      run(1);
    end
    out_ready = 1'b1;
    run(20);
    chk("drain_all_rl2", g[0].exp_i, fwr);
    chk("drain_all_rl1", g[1].exp_i, fwr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
